// File: rtl/lru_victim_ctrl.sv
// lru_victim_ctrl: 8-way refill/victim controller and sole writer of the LRU age tracker.
module lru_victim_ctrl #(
   parameter int TAG_W       = 20,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [TAG_W-1:0] i_req_tag,
   input  logic [7:0]       i_req_hit_8,
   input  logic [7:0]       i_valid_8,
   input  logic [2:0]       i_rank0,
   input  logic [2:0]       i_rank1,
   input  logic [2:0]       i_rank2,
   input  logic [2:0]       i_rank3,
   input  logic [2:0]       i_rank4,
   input  logic [2:0]       i_rank5,
   input  logic [2:0]       i_rank6,
   input  logic [2:0]       i_rank7,
   output logic [7:0]       o_hit_way_8,
   output logic             o_hit_sig,
   output logic             o_lru_write_enable,
   output logic             o_fill_req,
   output logic [2:0]       o_fill_way,
   output logic [TAG_W-1:0] o_fill_tag,
   input  logic             i_fill_ack,
   output logic             o_resp_valid,
   output logic [2:0]       o_resp_way,
   output logic             o_resp_hit,
   output logic             o_err
);
   typedef enum logic [1:0] {IDLE, VICTIM, FILL, UPDATE} state_t;
   state_t           r_state, w_state;
   logic [TAG_W-1:0] r_tag, w_tag;
   logic [7:0]       r_valid, w_valid, r_cnt, w_cnt, r_hit_way, w_hit_way;
   logic             r_ready, w_ready, r_upd, w_upd, r_fill_req, w_fill_req, r_err, w_err;
   logic             r_resp_hit, w_resp_hit;
   logic [2:0]       r_fill_way, w_fill_way, r_resp_way, w_resp_way;
   logic [2:0]       w_low, w_inv_way, w_r7_way;
   logic             w_has7;
   logic [2:0]       w_rank [8];
   assign w_rank = '{i_rank0, i_rank1, i_rank2, i_rank3, i_rank4, i_rank5, i_rank6, i_rank7};
   always_comb begin
      w_low     = '0;
      w_inv_way = '0;
      w_r7_way  = '0;
      w_has7    = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (i_req_hit_8[i]) w_low = 3'(i);
         if (!r_valid[i]) w_inv_way = 3'(i);
         if (w_rank[i] == 3'd7) begin
            w_r7_way = 3'(i);
            w_has7   = 1'b1;
         end
      end
   end
   always_comb begin
      w_state    = r_state;
      w_tag      = r_tag;
      w_valid    = r_valid;
      w_cnt      = r_cnt;
      w_fill_req = 1'b0;
      w_fill_way = r_fill_way;
      w_upd      = 1'b0;
      w_hit_way  = '0;
      w_resp_way = r_resp_way;
      w_resp_hit = r_resp_hit;
      w_err      = 1'b0;
      case (r_state)
         IDLE: if (i_req_valid && r_ready) begin
            w_tag   = i_req_tag;
            w_valid = i_valid_8;
            if (|i_req_hit_8) begin
               w_state    = UPDATE;
               w_upd      = 1'b1;
               w_hit_way  = 8'd1 << w_low;
               w_resp_way = w_low;
               w_resp_hit = 1'b1;
               w_err      = |(i_req_hit_8 & (i_req_hit_8 - 8'd1));
            end else w_state = VICTIM;
         end
         VICTIM: begin
            w_state    = FILL;
            w_fill_req = 1'b1;
            w_cnt      = '0;
            w_fill_way = !(&r_valid) ? w_inv_way : (w_has7 ? w_r7_way : 3'd0);
            w_err      = &r_valid && !w_has7;
         end
         FILL: if (i_fill_ack) begin
            w_state    = UPDATE;
            w_upd      = 1'b1;
            w_hit_way  = 8'd1 << r_fill_way;
            w_resp_way = r_fill_way;
            w_resp_hit = 1'b0;
         end else if (r_cnt == 8'(TIMEOUT_CYC - 1)) begin
            w_state = IDLE;
            w_err   = 1'b1;
         end else begin
            w_cnt      = r_cnt + 8'd1;
            w_fill_req = 1'b1;
         end
         default: w_state = IDLE;
      endcase
      w_ready = (w_state == IDLE);
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_tag      <= '0;
         r_valid    <= '0;
         r_cnt      <= '0;
         r_ready    <= 1'b0;
         r_upd      <= 1'b0;
         r_hit_way  <= '0;
         r_fill_req <= 1'b0;
         r_fill_way <= '0;
         r_resp_way <= '0;
         r_resp_hit <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_tag      <= w_tag;
         r_valid    <= w_valid;
         r_cnt      <= w_cnt;
         r_ready    <= w_ready;
         r_upd      <= w_upd;
         r_hit_way  <= w_hit_way;
         r_fill_req <= w_fill_req;
         r_fill_way <= w_fill_way;
         r_resp_way <= w_resp_way;
         r_resp_hit <= w_resp_hit;
         r_err      <= w_err;
      end
   end
   assign o_req_ready        = r_ready;
   assign o_hit_way_8        = r_hit_way;
   assign o_hit_sig          = r_upd;
   assign o_lru_write_enable = r_upd;
   assign o_resp_valid       = r_upd;
   assign o_resp_way         = r_resp_way;
   assign o_resp_hit         = r_resp_hit;
   assign o_fill_req         = r_fill_req;
   assign o_fill_way         = r_fill_way;
   assign o_fill_tag         = r_tag;
   assign o_err              = r_err;
endmodule
